// File: rtl/flag_branch_if.sv
// Bundles the EX flag-write, ID branch-query and debug-counter signals
// exchanged between the pipeline and the flag/branch unit.
interface flag_branch_if #(
  parameter int CNT_W = 16
);
  logic             ex_set_flags;
  logic             ex_flush;
  logic             ex_negative;
  logic             ex_zero;
  logic             ex_overflow;
  logic             ex_carry_out;
  logic [1:0]       id_br_type;
  logic [3:0]       id_cond;
  logic             id_cbz_is_zero;
  logic             id_stall;
  logic             cnt_clear;
  logic [3:0]       flags_q;
  logic             take_branch;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output ex_set_flags, ex_flush, ex_negative, ex_zero, ex_overflow, ex_carry_out,
    output id_br_type, id_cond, id_cbz_is_zero, id_stall, cnt_clear,
    input  flags_q, take_branch, taken_count
  );

  modport slave (
    input  ex_set_flags, ex_flush, ex_negative, ex_zero, ex_overflow, ex_carry_out,
    input  id_br_type, id_cond, id_cbz_is_zero, id_stall, cnt_clear,
    output flags_q, take_branch, taken_count
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural NZVC flag register, ID-stage branch resolution with optional
// EX-flag forwarding, and a saturating taken-branch counter.
module flag_branch_unit #(
  parameter int CNT_W  = 16,
  parameter bit FWD_EN = 1'b1
) (
  input logic           clk,
  input logic           reset,
  flag_branch_if.slave  bus
);

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_B    = 2'b01;
  localparam logic [1:0] BR_COND = 2'b10;
  localparam logic [1:0] BR_CBZ  = 2'b11;

  logic [3:0]       flags_reg;
  logic [3:0]       ex_flags;
  logic [3:0]       eff_flags;
  logic             flag_wr;
  logic             take;
  logic [CNT_W-1:0] cnt_reg;

  assign ex_flags = {bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry_out};
  assign flag_wr  = bus.ex_set_flags & ~bus.ex_flush;

  // A squashed EX instruction must neither update nor forward its flags.
  assign eff_flags = (FWD_EN && flag_wr) ? ex_flags : flags_reg;

  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c, gt;
    n  = f[3];
    z  = f[2];
    v  = f[1];
    c  = f[0];
    gt = ~z & (n == v);
    case (cond)
      4'b0000: cond_true = z;
      4'b0001: cond_true = ~z;
      4'b0010: cond_true = c;
      4'b0011: cond_true = ~c;
      4'b0100: cond_true = n;
      4'b0101: cond_true = ~n;
      4'b0110: cond_true = v;
      4'b0111: cond_true = ~v;
      4'b1000: cond_true = c & ~z;
      4'b1001: cond_true = ~(c & ~z);
      4'b1010: cond_true = (n == v);
      4'b1011: cond_true = (n != v);
      4'b1100: cond_true = gt;
      4'b1101: cond_true = ~gt;
      default: cond_true = 1'b1;
    endcase
  endfunction

  always_comb begin
    take = 1'b0;
    case (bus.id_br_type)
      BR_NONE: take = 1'b0;
      BR_B:    take = 1'b1;
      BR_COND: take = cond_true(bus.id_cond, eff_flags);
      BR_CBZ:  take = bus.id_cbz_is_zero;
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg <= 4'b0000;
    end else if (flag_wr) begin
      flags_reg <= ex_flags;
    end
  end

  // A stalled branch is only counted on the cycle its stall releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (bus.cnt_clear) begin
      cnt_reg <= '0;
    end else if (take && !bus.id_stall && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.flags_q     = flags_reg;
  assign bus.take_branch = take;
  assign bus.taken_count = cnt_reg;

endmodule
